// File: rtl/scr1_tcm_ram_pkg.sv
// Shared types and constants for the TCM dual-port RAM wrapper.
package scr1_tcm_ram_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } type_scr1_tcm_ram_state_e;

  localparam int unsigned SCR1_TCM_COLL_OLD = 0;
  localparam int unsigned SCR1_TCM_COLL_NEW = 1;

endpackage

// File: rtl/scr1_tcm_ram_array.sv
// Two-port byte-enable storage: port A read-only, port B read-first read/write.
// Reads are registered; there is no reset so the tools can map it to block RAM.
module scr1_tcm_ram_array #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NBYTES = WIDTH / 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              rena,
  input  logic [AW-1:0]     addra,
  output logic [WIDTH-1:0]  qa,
  input  logic              renb,
  input  logic              wenb,
  input  logic [NBYTES-1:0] webb,
  input  logic [AW-1:0]     addrb,
  input  logic [WIDTH-1:0]  datab,
  output logic [WIDTH-1:0]  qb
);

  (* ram_style = "block", syn_ramstyle = "block_ram" *)
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rena) qa <= mem[addra];
  end

  always_ff @(posedge clk) begin
    if (renb) qb <= mem[addrb];
    if (wenb) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (webb[i]) mem[addrb][i*8 +: 8] <= datab[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/scr1_tcm_dp_ram.sv
// TCM dual-port RAM wrapper: clear sequencer, request gating, A/B collision bypass,
// optional output register and read-valid strobes around scr1_tcm_ram_array.
module scr1_tcm_dp_ram
  import scr1_tcm_ram_pkg::*;
#(
  parameter int unsigned            SCR1_WIDTH     = 32,
  parameter int unsigned            SCR1_SIZE      = 32'h00010000,
  parameter int unsigned            SCR1_NBYTES    = SCR1_WIDTH / 8,
  parameter int unsigned            SCR1_OUT_REG   = 0,
  parameter int unsigned            SCR1_COLL_MODE = 0,
  parameter logic [SCR1_WIDTH-1:0]  SCR1_INIT_VAL  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_req,
  output logic                        rdy,
  input  logic                        rena,
  input  logic [$clog2(SCR1_SIZE)-3:0] addra,
  output logic [SCR1_WIDTH-1:0]       qa,
  output logic                        qa_vld,
  input  logic                        renb,
  input  logic                        wenb,
  input  logic [SCR1_NBYTES-1:0]      webb,
  input  logic [$clog2(SCR1_SIZE)-3:0] addrb,
  input  logic [SCR1_WIDTH-1:0]       datab,
  output logic [SCR1_WIDTH-1:0]       qb,
  output logic                        qb_vld
);

  localparam int unsigned AW             = $clog2(SCR1_SIZE) - 2;
  localparam int unsigned RAM_SIZE_WORDS = SCR1_SIZE / SCR1_NBYTES;
  localparam bit          COLL_BYPASS    = (SCR1_COLL_MODE == SCR1_TCM_COLL_NEW);

  type_scr1_tcm_ram_state_e state, state_nxt;
  logic [AW-1:0]            clr_cnt, clr_cnt_nxt;

  logic                     acc_a, acc_rb, acc_wb, clearing;
  logic                     vld_a1, vld_b1;
  logic [SCR1_NBYTES-1:0]   coll_mask;
  logic [SCR1_WIDTH-1:0]    coll_data;
  logic [SCR1_WIDTH-1:0]    ram_qa, ram_qb, qa_merge, qa_r, qb_r;

  // Clear sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RESET;
      clr_cnt <= '0;
      rdy     <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      rdy     <= (state_nxt == ST_READY);
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_RESET: begin
        state_nxt   = ST_CLEAR;
        clr_cnt_nxt = '0;
      end
      ST_CLEAR: begin
        if (clr_req) begin
          clr_cnt_nxt = '0;
        end else if (clr_cnt == AW'(RAM_SIZE_WORDS - 1)) begin
          state_nxt = ST_READY;
        end else begin
          clr_cnt_nxt = clr_cnt + AW'(1);
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  // Requests are only honoured once the array is initialised
  assign acc_a    = rdy & rena;
  assign acc_rb   = rdy & renb;
  assign acc_wb   = rdy & wenb;
  assign clearing = (state == ST_CLEAR);

  scr1_tcm_ram_array #(
    .WIDTH  (SCR1_WIDTH),
    .NBYTES (SCR1_NBYTES),
    .DEPTH  (RAM_SIZE_WORDS),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .rena  (acc_a),
    .addra (addra),
    .qa    (ram_qa),
    .renb  (acc_rb),
    .wenb  (clearing | acc_wb),
    .webb  (clearing ? {SCR1_NBYTES{1'b1}} : webb),
    .addrb (clearing ? clr_cnt : addrb),
    .datab (clearing ? SCR1_INIT_VAL : datab),
    .qb    (ram_qb)
  );

  // Valid pipeline, registered collision bypass and held read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_a1    <= 1'b0;
      vld_b1    <= 1'b0;
      coll_mask <= '0;
      coll_data <= '0;
      qa_r      <= '0;
      qb_r      <= '0;
    end else begin
      vld_a1    <= acc_a;
      vld_b1    <= acc_rb;
      coll_mask <= (COLL_BYPASS && acc_a && acc_wb && (addra == addrb)) ? webb : '0;
      coll_data <= datab;
      if (vld_a1) qa_r <= qa_merge;
      if (vld_b1) qb_r <= ram_qb;
    end
  end

  for (genvar i = 0; i < int'(SCR1_NBYTES); i++) begin : g_lane
    assign qa_merge[i*8 +: 8] = coll_mask[i] ? coll_data[i*8 +: 8] : ram_qa[i*8 +: 8];
  end

  if (SCR1_OUT_REG != 0) begin : g_out_reg
    logic vld_a2, vld_b2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_a2 <= 1'b0;
        vld_b2 <= 1'b0;
      end else begin
        vld_a2 <= vld_a1;
        vld_b2 <= vld_b1;
      end
    end

    assign qa     = qa_r;
    assign qa_vld = vld_a2;
    assign qb     = qb_r;
    assign qb_vld = vld_b2;
  end else begin : g_out_direct
    // Array output is forwarded on the completing cycle, then held in qa_r/qb_r
    assign qa     = vld_a1 ? qa_merge : qa_r;
    assign qa_vld = vld_a1;
    assign qb     = vld_b1 ? ram_qb : qb_r;
    assign qb_vld = vld_b1;
  end

endmodule

// File: tb/tb_scr1_tcm_dp_ram.sv
// Directed bench: dut0 = latency 1 / old-data collisions, dut1 = latency 2 / merged collisions.
module tb_scr1_tcm_dp_ram;

  localparam int unsigned W     = 32;
  localparam int unsigned SIZE  = 64;
  localparam int unsigned NB    = 4;
  localparam int unsigned AW    = 4;
  localparam int unsigned WORDS = 16;

  logic          clk = 1'b0;
  logic          rst, clr_req, rena, renb, wenb;
  logic [NB-1:0] webb;
  logic [AW-1:0] addra, addrb;
  logic [W-1:0]  datab;
  logic          rdy0, rdy1, qa_vld0, qa_vld1, qb_vld0, qb_vld1;
  logic [W-1:0]  qa0, qa1, qb0, qb1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scr1_tcm_dp_ram #(.SCR1_WIDTH(W), .SCR1_SIZE(SIZE), .SCR1_OUT_REG(0), .SCR1_COLL_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .rdy(rdy0),
    .rena(rena), .addra(addra), .qa(qa0), .qa_vld(qa_vld0),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab),
    .qb(qb0), .qb_vld(qb_vld0)
  );

  scr1_tcm_dp_ram #(.SCR1_WIDTH(W), .SCR1_SIZE(SIZE), .SCR1_OUT_REG(1), .SCR1_COLL_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .rdy(rdy1),
    .rena(rena), .addra(addra), .qa(qa1), .qa_vld(qa_vld1),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab),
    .qb(qb1), .qb_vld(qb_vld1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rena = 1'b0; renb = 1'b0; wenb = 1'b0; clr_req = 1'b0; webb = '0;
  endtask

  task automatic write_b(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NB-1:0] be);
    wenb = 1'b1; addrb = a; datab = d; webb = be;
    step();
    wenb = 1'b0; webb = '0;
  endtask

  // v0/d0: dut0 one cycle after the request; v1e: dut1 at that point; v1/d1: dut1 a cycle later
  task automatic read_a(input logic [AW-1:0] a, output logic v0, output logic [W-1:0] d0,
                        output logic v1e, output logic v1, output logic [W-1:0] d1);
    rena = 1'b1; addra = a;
    step();
    rena = 1'b0;
    v0 = qa_vld0; d0 = qa0; v1e = qa_vld1;
    step();
    v1 = qa_vld1; d1 = qa1;
  endtask

  task automatic read_b(input logic [AW-1:0] a, output logic v0, output logic [W-1:0] d0,
                        output logic v1e, output logic v1, output logic [W-1:0] d1);
    renb = 1'b1; addrb = a;
    step();
    renb = 1'b0;
    v0 = qb_vld0; d0 = qb0; v1e = qb_vld1;
    step();
    v1 = qb_vld1; d1 = qb1;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!(rdy0 && rdy1) && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic v0, v1e, v1;
    logic [W-1:0] d0, d1;
    rst = 1'b1; idle(); addra = '0; addrb = '0; datab = '0;
    repeat (3) step();
    checks++;
    if ({rdy0, rdy1, qa_vld0, qa_vld1, qb_vld0, qb_vld1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy/vld=%b required 000000", {rdy0, rdy1, qa_vld0, qa_vld1, qb_vld0, qb_vld1});
    end
    checks++;
    if ({qa0, qa1, qb0, qb1} !== '0) begin
      errors++;
      $display("FAIL reset_data: qa0=%h qa1=%h qb0=%h qb1=%h required 0", qa0, qa1, qb0, qb1);
    end
    rst = 1'b0;
    step();
    checks++;
    if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL clear_entry: rdy0=%b rdy1=%b required 0", rdy0, rdy1);
    end
    wait_rdy(n);
    checks++;
    if (n != int'(WORDS)) begin
      errors++;
      $display("FAIL clear_length: rdy after %0d cycles required %0d", n, WORDS);
    end
    for (int i = 0; i < int'(WORDS); i++) begin
      read_a(AW'(i), v0, d0, v1e, v1, d1);
      checks++;
      if (v0 !== 1'b1 || d0 !== 32'h0 || v1e !== 1'b0 || v1 !== 1'b1 || d1 !== 32'h0) begin
        errors++;
        $display("FAIL init_read addr %0d: v0=%b d0=%h v1e=%b v1=%b d1=%h required 1/0/0/1/0", i, v0, d0, v1e, v1, d1);
      end
    end
  endtask

  task automatic test_byte_write();
    logic v0, v1e, v1;
    logic [W-1:0] d0, d1;
    write_b(4'd3, 32'hA1B2C3D4, 4'b0101);
    write_b(4'd3, 32'hFFFFFFFF, 4'b0000);
    read_a(4'd3, v0, d0, v1e, v1, d1);
    checks++;
    if (v0 !== 1'b1 || d0 !== 32'h00B200D4 || v1e !== 1'b0) begin
      errors++;
      $display("FAIL byte_write dut0: vld=%b qa=%h dut1_early_vld=%b required 1 00b200d4 0", v0, d0, v1e);
    end
    checks++;
    if (v1 !== 1'b1 || d1 !== 32'h00B200D4) begin
      errors++;
      $display("FAIL byte_write dut1: vld=%b qa=%h required 1 00b200d4", v1, d1);
    end
  endtask

  task automatic test_collision();
    logic v0, v1e, v1;
    logic [W-1:0] d0, d1;
    write_b(4'd5, 32'h11111111, 4'b1111);
    rena = 1'b1; addra = 4'd5;
    wenb = 1'b1; addrb = 4'd5; datab = 32'hFFFFFFFF; webb = 4'b0011;
    step();
    idle();
    checks++;
    if (qa_vld0 !== 1'b1 || qa0 !== 32'h11111111) begin
      errors++;
      $display("FAIL coll_old: vld=%b qa=%h required 1 11111111", qa_vld0, qa0);
    end
    step();
    checks++;
    if (qa_vld1 !== 1'b1 || qa1 !== 32'h1111FFFF) begin
      errors++;
      $display("FAIL coll_new: vld=%b qa=%h required 1 1111ffff", qa_vld1, qa1);
    end
    read_a(4'd5, v0, d0, v1e, v1, d1);
    checks++;
    if (d0 !== 32'h1111FFFF || d1 !== 32'h1111FFFF || !v0 || !v1) begin
      errors++;
      $display("FAIL coll_after: d0=%h d1=%h v0=%b v1=%b required 1111ffff x2 valid", d0, d1, v0, v1);
    end
  endtask

  task automatic test_read_first();
    logic v0, v1e, v1;
    logic [W-1:0] d0, d1;
    write_b(4'd7, 32'hCAFEBABE, 4'b1111);
    renb = 1'b1; wenb = 1'b1; addrb = 4'd7; datab = 32'h12345678; webb = 4'b1111;
    step();
    idle();
    checks++;
    if (qb_vld0 !== 1'b1 || qb0 !== 32'hCAFEBABE || qb_vld1 !== 1'b0) begin
      errors++;
      $display("FAIL read_first dut0: vld=%b qb=%h dut1_vld=%b required 1 cafebabe 0", qb_vld0, qb0, qb_vld1);
    end
    step();
    checks++;
    if (qb_vld1 !== 1'b1 || qb1 !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL read_first dut1: vld=%b qb=%h required 1 cafebabe", qb_vld1, qb1);
    end
    read_b(4'd7, v0, d0, v1e, v1, d1);
    checks++;
    if (v0 !== 1'b1 || d0 !== 32'h12345678 || v1e !== 1'b0 || v1 !== 1'b1 || d1 !== 32'h12345678) begin
      errors++;
      $display("FAIL read_after_write: v0=%b d0=%h v1e=%b v1=%b d1=%h required 1 12345678 0 1 12345678", v0, d0, v1e, v1, d1);
    end
  endtask

  task automatic test_clear();
    int n;
    logic any_vld;
    logic v0, v1e, v1;
    logic [W-1:0] d0, d1;
    logic [AW-1:0] addrs [3];
    addrs[0] = 4'd3; addrs[1] = 4'd5; addrs[2] = 4'd7;
    rena = 1'b1; addra = 4'd5; clr_req = 1'b1;
    step();
    idle();
    checks++;
    if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL clr_drop_rdy: rdy0=%b rdy1=%b required 0", rdy0, rdy1);
    end
    checks++;
    if (qa_vld0 !== 1'b1 || qa0 !== 32'h1111FFFF) begin
      errors++;
      $display("FAIL clr_same_cycle dut0: vld=%b qa=%h required 1 1111ffff", qa_vld0, qa0);
    end
    step();
    checks++;
    if (qa_vld1 !== 1'b1 || qa1 !== 32'h1111FFFF) begin
      errors++;
      $display("FAIL clr_same_cycle dut1: vld=%b qa=%h required 1 1111ffff", qa_vld1, qa1);
    end
    any_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rena = 1'b1; addra = 4'd3; renb = 1'b1;
      wenb = 1'b1; addrb = 4'd3; datab = 32'hFFFFFFFF; webb = 4'b1111;
      step();
      any_vld = any_vld | qa_vld0 | qa_vld1 | qb_vld0 | qb_vld1;
    end
    idle();
    step();
    any_vld = any_vld | qa_vld0 | qa_vld1 | qb_vld0 | qb_vld1;
    checks++;
    if (any_vld !== 1'b0) begin
      errors++;
      $display("FAIL gated_while_clear: a vld strobe was %b required 0", any_vld);
    end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wait_rdy(n);
    checks++;
    if (n != int'(WORDS)) begin
      errors++;
      $display("FAIL clear_restart: rdy after %0d cycles required %0d", n, WORDS);
    end
    for (int i = 0; i < 3; i++) begin
      read_a(addrs[i], v0, d0, v1e, v1, d1);
      checks++;
      if (v0 !== 1'b1 || d0 !== 32'h0 || v1 !== 1'b1 || d1 !== 32'h0) begin
        errors++;
        $display("FAIL cleared addr %0d: v0=%b d0=%h v1=%b d1=%h required 1 0 1 0", addrs[i], v0, d0, v1, d1);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    logic v0, v1e, v1;
    logic [W-1:0] d0, d1;
    write_b(4'd2, 32'hDEADBEEF, 4'b1111);
    read_a(4'd2, v0, d0, v1e, v1, d1);
    checks++;
    if (d0 !== 32'hDEADBEEF || d1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL pre_reset_read: d0=%h d1=%h required deadbeef", d0, d1);
    end
    rena = 1'b1; addra = 4'd2;
    step();
    rena = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (qa1 !== 32'h0 || qa_vld1 !== 1'b0 || qa0 !== 32'h0 || qa_vld0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: qa0=%h vld0=%b qa1=%h vld1=%b required 0", qa0, qa_vld0, qa1, qa_vld1);
    end
    v1 = 1'b0;
    repeat (2) begin
      step();
      v1 = v1 | qa_vld1;
    end
    checks++;
    if (v1 !== 1'b0 || qa1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_no_vld: vld seen=%b qa1=%h required 0 0", v1, qa1);
    end
    rst = 1'b0;
    wait_rdy(n);
    checks++;
    if (n != int'(WORDS) + 1) begin
      errors++;
      $display("FAIL reset_reclear: rdy after %0d cycles required %0d", n, WORDS + 1);
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_collision();
    test_read_first();
    test_clear();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
